iob_gpio_debounce: RTL and testbench

Input conditioning stage placed directly upstream of the GPIO peripheral's dedicated inputs (BTN_1, BTN_2, JUMP_IN, SWITCH). It synchronises each raw asynchronous pin into the `clk` domain and debounces it with a per-channel state machine and counter. It produces a clean level, single-cycle rise and fall pulses, and a sticky press flag that software clears through the peripheral. The clean levels feed the GPIO input read registers.

---
 rtl/iob_gpio_debounce_if.sv | 22 ++
 rtl/iob_gpio_debounce.sv | 127 ++++++++++++
 tb/tb_iob_gpio_debounce.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/iob_gpio_debounce_if.sv
// Pin-side bundle of the GPIO input conditioner: raw pins and flag clears in,
// clean levels, edge pulses and sticky press flags out.
interface iob_gpio_debounce_if #(
  parameter int unsigned N_IN = 4
);
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] press_clr;
  logic [N_IN-1:0] clean_out;
  logic [N_IN-1:0] rise_pulse;
  logic [N_IN-1:0] fall_pulse;
  logic [N_IN-1:0] press_flag;

  modport master (
    output raw_in, press_clr,
    input  clean_out, rise_pulse, fall_pulse, press_flag
  );

  modport slave (
    input  raw_in, press_clr,
    output clean_out, rise_pulse, fall_pulse, press_flag
  );
endinterface

// File: rtl/iob_gpio_debounce.sv
// Per-channel 2-flop synchroniser plus debounce FSM/counter producing a clean
// level, one-cycle rise/fall pulses and a software-cleared press flag.
module iob_gpio_debounce #(
  parameter int unsigned N_IN            = 4,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  iob_gpio_debounce_if.slave    bus
);

  if (DEBOUNCE_CYCLES == 0 || 64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("iob_gpio_debounce: DEBOUNCE_CYCLES must be in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  logic [N_IN-1:0]  s1;
  logic [N_IN-1:0]  s2;
  state_t           state   [N_IN];
  state_t           state_n [N_IN];
  logic [CNT_W-1:0] cnt     [N_IN];
  logic [CNT_W-1:0] cnt_n   [N_IN];
  logic [N_IN-1:0]  clean_q, clean_n;
  logic [N_IN-1:0]  rise_q,  rise_n;
  logic [N_IN-1:0]  fall_q,  fall_n;
  logic [N_IN-1:0]  flag_q,  flag_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      flag_q  <= '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        state[i] <= STABLE_LO;
        cnt[i]   <= '0;
      end
    end else begin
      s1      <= bus.raw_in;
      s2      <= s1;
      clean_q <= clean_n;
      rise_q  <= rise_n;
      fall_q  <= fall_n;
      flag_q  <= flag_n;
      for (int unsigned i = 0; i < N_IN; i++) begin
        state[i] <= state_n[i];
        cnt[i]   <= cnt_n[i];
      end
    end
  end

  always_comb begin
    clean_n = clean_q;
    rise_n  = '0;
    fall_n  = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      state_n[i] = state[i];
      cnt_n[i]   = cnt[i];
      case (state[i])
        STABLE_LO: begin
          if (s2[i]) begin
            state_n[i] = WAIT_HI;
            cnt_n[i]   = '0;
          end
        end
        WAIT_HI: begin
          if (!s2[i]) begin
            state_n[i] = STABLE_LO;
            cnt_n[i]   = '0;
          end else if (cnt[i] == CNT_MAX) begin
            state_n[i] = STABLE_HI;
            cnt_n[i]   = '0;
            clean_n[i] = 1'b1;
            rise_n[i]  = 1'b1;
          end else begin
            cnt_n[i] = cnt[i] + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s2[i]) begin
            state_n[i] = WAIT_LO;
            cnt_n[i]   = '0;
          end
        end
        WAIT_LO: begin
          if (s2[i]) begin
            state_n[i] = STABLE_HI;
            cnt_n[i]   = '0;
          end else if (cnt[i] == CNT_MAX) begin
            state_n[i] = STABLE_LO;
            cnt_n[i]   = '0;
            clean_n[i] = 1'b0;
            fall_n[i]  = 1'b1;
          end else begin
            cnt_n[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          state_n[i] = STABLE_LO;
          cnt_n[i]   = '0;
        end
      endcase
    end
  end

  // Flag follows the registered pulse, so a clear in the pulse cycle loses to the set.
  always_comb begin
    flag_n = rise_q | (flag_q & ~bus.press_clr);
  end

  assign bus.clean_out  = clean_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.press_flag = flag_q;

endmodule

// File: tb/tb_iob_gpio_debounce.sv
// Directed bench for iob_gpio_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
module tb_iob_gpio_debounce;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  iob_gpio_debounce_if #(.N_IN(4)) bus ();

  iob_gpio_debounce #(
    .N_IN(4),
    .CNT_W(3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] raw;
    logic [3:0] clr;
    logic       rst;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] flag;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] raw, input logic [3:0] clr, input logic r,
                     input logic [3:0] clean, input logic [3:0] rise,
                     input logic [3:0] fall, input logic [3:0] flag);
    vec_t v;
    v.raw = raw; v.clr = clr; v.rst = r;
    v.clean = clean; v.rise = rise; v.fall = fall; v.flag = flag;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int rises;
    logic [3:0] pat [8];

    // reset and idle
    for (int i = 0; i < 2; i++)  add(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // clean press on channel 0
    for (int i = 0; i < 6; i++)  add(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++)  add(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    // channel 2 rise
    for (int i = 0; i < 6; i++)  add(4'b0101, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0101, 4'b0000, 1'b0, 4'b0101, 4'b0100, 4'b0000, 4'b0001);
    for (int i = 0; i < 3; i++)  add(4'b0101, 4'b0000, 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0101);
    // channel 2 release
    for (int i = 0; i < 6; i++)  add(4'b0001, 4'b0000, 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0101);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0100, 4'b0101);
    for (int i = 0; i < 2; i++)  add(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0101);
    // software clear of both flags
    add(4'b0001, 4'b0101, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);

    bus.raw_in = '0;
    bus.press_clr = '0;
    rst = 1'b1;

    foreach (vecs[k]) begin
      bus.raw_in    = vecs[k].raw;
      bus.press_clr = vecs[k].clr;
      rst           = vecs[k].rst;
      step();
      check($sformatf("vec%0d", k),
            {bus.clean_out, bus.rise_pulse, bus.fall_pulse, bus.press_flag},
            {vecs[k].clean, vecs[k].rise, vecs[k].fall, vecs[k].flag});
    end

    // bounce rejection on channel 1
    pat = '{4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    rises = 0;
    for (int j = 0; j < 14; j++) begin
      bus.raw_in = (j < 8) ? pat[j] : 4'b0011;
      step();
      if (bus.rise_pulse[1]) rises++;
      check1($sformatf("bounce_clean1_e%0d", j), bus.clean_out[1], j >= 10);
      check1($sformatf("bounce_rise1_e%0d", j), bus.rise_pulse[1], j == 10);
    end
    tests++;
    if (rises != 1) begin
      fails++;
      $display("FAIL bounce_rise_count: got %0d expected 1", rises);
    end

    // clear colliding with the rise pulse on channel 3
    bus.raw_in = 4'b1011;
    for (int j = 0; j < 6; j++) begin
      step();
      check1($sformatf("ch3_clean_e%0d", j), bus.clean_out[3], 1'b0);
    end
    step();
    check1("ch3_rise_e6", bus.rise_pulse[3], 1'b1);
    check1("ch3_clean_e6", bus.clean_out[3], 1'b1);
    check1("ch3_flag_e6", bus.press_flag[3], 1'b0);
    bus.press_clr = 4'b1000;
    step();
    bus.press_clr = 4'b0000;
    check1("ch3_flag_priority", bus.press_flag[3], 1'b1);
    check1("ch3_rise_e7", bus.rise_pulse[3], 1'b0);
    step();
    step();
    check1("ch3_flag_hold", bus.press_flag[3], 1'b1);
    bus.press_clr = 4'b1000;
    step();
    bus.press_clr = 4'b0000;
    check1("ch3_flag_cleared", bus.press_flag[3], 1'b0);

    // reset while channel 0 counts in WAIT_HI
    bus.raw_in = 4'b1010;
    for (int j = 0; j < 10; j++) step();
    check1("ch0_low_before_rst", bus.clean_out[0], 1'b0);
    bus.raw_in = 4'b1011;
    for (int j = 0; j < 5; j++) begin
      step();
      check1($sformatf("ch0_wait_e%0d", j), bus.clean_out[0], 1'b0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_outputs",
          {bus.clean_out, bus.rise_pulse, bus.fall_pulse, bus.press_flag}, 16'h0000);
    for (int j = 6; j <= 12; j++) begin
      step();
      check1($sformatf("post_rst_clean0_e%0d", j), bus.clean_out[0], j == 12);
      check1($sformatf("post_rst_rise0_e%0d", j), bus.rise_pulse[0], j == 12);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
